reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, data word width in bits; legal values are multiples of 8, minimum 8.
REQ-002 The block SHALL have parameter ADDR_W, default 3, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 The block SHALL have one clock and an asynchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  async reset, active high.
REQ-005 rd_addr_0, rd_addr_1  in  ADDR_W  read port addresses.
REQ-006 rd_data_0, rd_data_1  out  DATA_W  read data, combinational.
REQ-007 rd_busy_0, rd_busy_1  out  1  scoreboard busy bit of the addressed register, combinational.
REQ-008 we_0, we_1  in  1  write enables for write ports 0 and 1.
REQ-009 wa_0, wa_1  in  ADDR_W  write addresses.
REQ-010 wd_0, wd_1  in  DATA_W  write data.
REQ-011 be_0, be_1  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
REQ-012 sb_set  in  1  mark register sb_addr busy (pending producer).
REQ-013 sb_addr  in  ADDR_W  scoreboard set address.
REQ-014 busy_any  out  1  OR of all busy bits, registered state.
REQ-015 busy_cnt  out  ADDR_W+1  count of busy registers, registered.

Function
REQ-016 Writes SHALL commit on the rising clk edge; only bytes with be=1 update; a write with we=1 and be all-zero SHALL change no data but still counts as a write for scoreboard clearing.
REQ-017 Same address on both ports in one cycle: per byte, port 1 SHALL win where be_1=1; port 0 bytes SHALL apply where be_1=0.
REQ-018 With BYPASS=0, rd_data_n SHALL equal the stored register value (pre-edge).
REQ-019 With BYPASS=1, rd_data_n SHALL, per byte, return wd_1 if we_1, wa_1==rd_addr_n and be_1 set; else wd_0 under the same conditions for port 0; else the stored value.
REQ-020 Each register SHALL have a busy bit; sb_set=1 SHALL set busy[sb_addr] at the edge.
REQ-021 Any write (we_n=1) to address a SHALL clear busy[a] at the edge.
REQ-022 Simultaneous set and clear of the same address SHALL leave the bit set (new producer wins).
REQ-023 rd_busy_n SHALL reflect registered busy state only (no bypass of set or clear).
REQ-024 busy_cnt SHALL be updated at the same edge as the busy bits and always equal the popcount of the busy vector; busy_any SHALL equal (busy_cnt != 0).
REQ-025 busy_cnt SHALL reach DEPTH when all bits are set without wrap; it SHALL never underflow.
REQ-026 Out-of-range conditions do not exist (addresses span exactly DEPTH); no X SHALL propagate from unwritten registers after reset.

Reset
REQ-027 rst=1 SHALL asynchronously clear all registers to 0, all busy bits to 0, busy_cnt to 0, busy_any to 0, independent of clk.
REQ-028 Writes and sb_set presented while rst=1 SHALL be ignored; the first commit SHALL occur on the first rising edge after rst deasserts.
REQ-029 Reset asserted mid-burst SHALL discard any in-flight write of that cycle; rd_data SHALL read 0 immediately (BYPASS path still forwards wd if we is held).

Verification
REQ-030 Reset, then we_0=1, wa_0=3, wd_0=16'hA5A5, be_0=2'b11; next cycle rd_addr_0=3 -> rd_data_0=16'hA5A5, rd_data_1 at addr 4 = 0.
REQ-031 Collision: wa_0=wa_1=5, wd_0=16'h1111, be_0=11, wd_1=16'h2222, be_1=10 -> reg5=16'h2211.
REQ-032 BYPASS=1: reg2=16'h00FF, same cycle we_0 wa_0=2 wd_0=16'hAB00 be_0=10, rd_addr_0=2 -> rd_data_0=16'hABFF combinationally; BYPASS=0 build -> 16'h00FF.
REQ-033 Scoreboard: sb_set to 1,2,7 on three edges -> busy_cnt=3, busy_any=1; write reg2 with sb_set on 2 same cycle -> busy[2] stays 1, cnt=3; write reg1, be=00 -> cnt=2.
REQ-034 Set all 8 busy bits -> busy_cnt=8; clear all via writes -> busy_cnt=0, busy_any=0.
REQ-035 Assert rst asynchronously between edges after loading reg6=16'h1234 busy[6]=1 -> rd_data=0, rd_busy=0, busy_cnt=0 before next edge.

Source files
------------

// File: rtl/reg_file_sb.sv
// Multi-port register file with byte enables, optional write-to-read
// forwarding and a per-register busy scoreboard with population count.
module reg_file_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     rd_addr_0,
  input  logic [ADDR_W-1:0]     rd_addr_1,
  output logic [DATA_W-1:0]     rd_data_0,
  output logic [DATA_W-1:0]     rd_data_1,
  output logic                  rd_busy_0,
  output logic                  rd_busy_1,
  input  logic                  we_0,
  input  logic                  we_1,
  input  logic [ADDR_W-1:0]     wa_0,
  input  logic [ADDR_W-1:0]     wa_1,
  input  logic [DATA_W-1:0]     wd_0,
  input  logic [DATA_W-1:0]     wd_1,
  input  logic [DATA_W/8-1:0]   be_0,
  input  logic [DATA_W/8-1:0]   be_1,
  input  logic                  sb_set,
  input  logic [ADDR_W-1:0]     sb_addr,
  output logic                  busy_any,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              r_any;

  // A new producer outranks a write that retires the old one.
  always_comb begin
    w_busy_nxt = r_busy;
    w_cnt_nxt  = '0;
    for (int a = 0; a < DEPTH; a++) begin
      if (we_0 && wa_0 == ADDR_W'(a))
        w_busy_nxt[a] = 1'b0;
      if (we_1 && wa_1 == ADDR_W'(a))
        w_busy_nxt[a] = 1'b0;
      if (sb_set && sb_addr == ADDR_W'(a))
        w_busy_nxt[a] = 1'b1;
      w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[a]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
      r_any  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
      r_any  <= |w_busy_nxt;
    end
  end

  // Port 1 owns any byte it enables on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < DEPTH; a++)
        r_mem[a] <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        for (int b = 0; b < NB; b++) begin
          if (we_1 && wa_1 == ADDR_W'(a) && be_1[b])
            r_mem[a][8*b +: 8] <= wd_1[8*b +: 8];
          else if (we_0 && wa_0 == ADDR_W'(a) && be_0[b])
            r_mem[a][8*b +: 8] <= wd_0[8*b +: 8];
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] f_read(
    input logic [ADDR_W-1:0] ra
  );
    logic [DATA_W-1:0] v;
    v = r_mem[ra];
    if (BYPASS != 0) begin
      for (int b = 0; b < NB; b++) begin
        if (we_1 && wa_1 == ra && be_1[b])
          v[8*b +: 8] = wd_1[8*b +: 8];
        else if (we_0 && wa_0 == ra && be_0[b])
          v[8*b +: 8] = wd_0[8*b +: 8];
      end
    end
    return v;
  endfunction

  always_comb begin
    rd_data_0 = f_read(rd_addr_0);
    rd_data_1 = f_read(rd_addr_1);
  end

  assign rd_busy_0 = r_busy[rd_addr_0];
  assign rd_busy_1 = r_busy[rd_addr_1];
  assign busy_cnt  = r_cnt;
  assign busy_any  = r_any;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one forwarding build and one
// non-forwarding build share all inputs.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_addr_0, rd_addr_1;
  logic        we_0, we_1;
  logic [2:0]  wa_0, wa_1;
  logic [15:0] wd_0, wd_1;
  logic [1:0]  be_0, be_1;
  logic        sb_set;
  logic [2:0]  sb_addr;

  logic [15:0] rd0, rd1, n_rd0, n_rd1;
  logic        rb0, rb1, n_rb0, n_rb1;
  logic        bany, n_bany;
  logic [3:0]  bcnt, n_bcnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_data_0(rd0), .rd_data_1(rd1),
    .rd_busy_0(rb0), .rd_busy_1(rb1),
    .we_0(we_0), .we_1(we_1), .wa_0(wa_0), .wa_1(wa_1),
    .wd_0(wd_0), .wd_1(wd_1), .be_0(be_0), .be_1(be_1),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .busy_any(bany), .busy_cnt(bcnt)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_data_0(n_rd0), .rd_data_1(n_rd1),
    .rd_busy_0(n_rb0), .rd_busy_1(n_rb1),
    .we_0(we_0), .we_1(we_1), .wa_0(wa_0), .wa_1(wa_1),
    .wd_0(wd_0), .wd_1(wd_1), .be_0(be_0), .be_1(be_1),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .busy_any(n_bany), .busy_cnt(n_bcnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we_0 = 1'b0; we_1 = 1'b0;
    be_0 = 2'b00; be_1 = 2'b00;
    sb_set = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [2:0] a, input logic [15:0] d,
                     input logic [1:0] be);
    we_0 = 1'b1; wa_0 = a; wd_0 = d; be_0 = be;
  endtask

  task automatic wr1(input logic [2:0] a, input logic [15:0] d,
                     input logic [1:0] be);
    we_1 = 1'b1; wa_1 = a; wd_1 = d; be_1 = be;
  endtask

  task automatic sbs(input logic [2:0] a);
    sb_set = 1'b1; sb_addr = a;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wa_0 = '0; wa_1 = '0; wd_0 = '0; wd_1 = '0;
    sb_addr = '0; rd_addr_0 = 3'd3; rd_addr_1 = 3'd4;
    wr0(3'd3, 16'hFFFF, 2'b11);
    sbs(3'd3);
    #1;
    chk("rst_cnt", 32'(bcnt), 32'd0);
    chk("rst_any", 32'(bany), 32'd0);
    chk("rst_rd_nb", 32'(n_rd0), 32'h0);
    tick();
    tick();
    chk("rst_wr_ign", 32'(n_rd0), 32'h0);
    chk("rst_sb_ign", 32'(rb0), 32'd0);
    idle();
    rst = 1'b0;
    #1;
    chk("post_rst_rd", 32'(rd0), 32'h0);

    wr0(3'd3, 16'hA5A5, 2'b11);
    tick();
    idle();
    rd_addr_0 = 3'd3; rd_addr_1 = 3'd4;
    #1;
    chk("wr_rd0", 32'(rd0), 32'hA5A5);
    chk("wr_rd1_blank", 32'(rd1), 32'h0);

    wr0(3'd5, 16'h1111, 2'b11);
    wr1(3'd5, 16'h2222, 2'b10);
    rd_addr_0 = 3'd5;
    #1;
    chk("coll_byp", 32'(rd0), 32'h2211);
    chk("coll_nobyp", 32'(n_rd0), 32'h0);
    tick();
    idle();
    #1;
    chk("coll_store", 32'(n_rd0), 32'h2211);

    wr0(3'd2, 16'h00FF, 2'b11);
    tick();
    idle();
    wr0(3'd2, 16'hAB00, 2'b10);
    rd_addr_0 = 3'd2;
    #1;
    chk("byp_merge", 32'(rd0), 32'hABFF);
    chk("nobyp_old", 32'(n_rd0), 32'h00FF);
    tick();
    idle();
    #1;
    chk("byp_commit", 32'(n_rd0), 32'hABFF);

    wr0(3'd3, 16'hBBCC, 2'b01);
    wr1(3'd3, 16'hDD00, 2'b10);
    rd_addr_1 = 3'd3;
    #1;
    chk("byp_mix", 32'(rd1), 32'hDDCC);
    chk("nobyp_mix", 32'(n_rd1), 32'hA5A5);
    tick();
    idle();
    #1;
    chk("mix_commit", 32'(n_rd1), 32'hDDCC);

    sbs(3'd1); tick();
    sbs(3'd2); tick();
    sbs(3'd7);
    rd_addr_1 = 3'd7;
    #1;
    chk("busy_no_byp", 32'(rb1), 32'd0);
    tick();
    idle();
    rd_addr_0 = 3'd2;
    #1;
    chk("sb3_cnt", 32'(bcnt), 32'd3);
    chk("sb3_any", 32'(bany), 32'd1);
    chk("sb3_rb0", 32'(rb0), 32'd1);
    chk("sb3_rb1", 32'(rb1), 32'd1);

    wr0(3'd2, 16'h7777, 2'b11);
    sbs(3'd2);
    tick();
    idle();
    #1;
    chk("setclr_bit", 32'(rb0), 32'd1);
    chk("setclr_cnt", 32'(bcnt), 32'd3);

    wr1(3'd1, 16'hFFFF, 2'b00);
    rd_addr_0 = 3'd1;
    tick();
    idle();
    #1;
    chk("be0_clr_cnt", 32'(bcnt), 32'd2);
    chk("be0_clr_bit", 32'(rb0), 32'd0);
    chk("be0_nodata", 32'(rd0), 32'h0);

    sbs(3'd0); tick();
    sbs(3'd1); tick();
    sbs(3'd3); tick();
    sbs(3'd4); tick();
    sbs(3'd5); tick();
    sbs(3'd6); tick();
    idle();
    #1;
    chk("full_cnt", 32'(bcnt), 32'd8);
    chk("full_any", 32'(bany), 32'd1);

    wr0(3'd0, 16'h0, 2'b00);
    wr1(3'd1, 16'h0, 2'b00);
    tick();
    #1;
    chk("drain6", 32'(bcnt), 32'd6);
    for (int k = 1; k < 4; k++) begin
      wa_0 = 3'(2*k);
      wa_1 = 3'(2*k+1);
      tick();
    end
    idle();
    #1;
    chk("drain_cnt", 32'(bcnt), 32'd0);
    chk("drain_any", 32'(bany), 32'd0);

    wr0(3'd6, 16'h1234, 2'b11);
    sbs(3'd6);
    tick();
    idle();
    rd_addr_0 = 3'd6;
    #1;
    chk("ld6_data", 32'(n_rd0), 32'h1234);
    chk("ld6_busy", 32'(rb0), 32'd1);
    chk("ld6_cnt", 32'(bcnt), 32'd1);

    #1;
    rst = 1'b1;
    #1;
    chk("arst_data", 32'(n_rd0), 32'h0);
    chk("arst_busy", 32'(rb0), 32'd0);
    chk("arst_cnt", 32'(bcnt), 32'd0);
    chk("arst_any", 32'(bany), 32'd0);

    wr0(3'd6, 16'h5555, 2'b11);
    #1;
    chk("arst_byp", 32'(rd0), 32'h5555);
    chk("arst_nobyp", 32'(n_rd0), 32'h0);
    tick();
    chk("arst_edge", 32'(n_rd0), 32'h0);
    idle();
    rst = 1'b0;
    tick();
    chk("arst_after", 32'(rd0), 32'h0);
    chk("arst_cnt2", 32'(n_bcnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
